// File: rtl/db_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// db_ctrl_pkg
// Shared definitions for the double-buffer phase sequencer:
//   - DEF_CNT_W : default width of the depth, iteration and frame counters
//   - state_e   : sequencer phase encoding
// -----------------------------------------------------------------------------
package db_ctrl_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SWITCH,
    ST_STEADY,
    ST_DRAIN
  } state_e;

endpackage : db_ctrl_pkg

// File: rtl/db_budget_cnt.sv
// -----------------------------------------------------------------------------
// db_budget_cnt
// Clear/increment counter checked against a limit. This counter tracks how
// much of a buffer's write or read budget has been used.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en_i       : clock enable; low holds the count
//   clr_i      : clear to zero (takes priority over inc_i)
//   inc_i      : count one accepted strobe
//   limit_i    : budget for the current buffer
//   cnt_o      : current count
//   avail_o    : budget not yet exhausted (cnt < limit)
//   last_o     : this increment uses the final unit of budget
// -----------------------------------------------------------------------------
module db_budget_cnt
  import db_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         avail_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: cnt_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  // NOTE: registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q < limit_i);
  // Callers gate inc_i with avail_o, so limit_i is nonzero whenever inc_i is high.
  assign last_o  = (cnt_q == limit_i - W'(1)) & inc_i;

endmodule : db_budget_cnt

// File: rtl/db_phase_ctrl.sv
// -----------------------------------------------------------------------------
// db_phase_ctrl
// Phase sequencer for the double-buffered memory core in DB mode. It arbitrates
// producer writes and consumer reads onto the core strobes and enforces the
// per-buffer write budget (depth) and read budget (iter_cnt). It also issues
// the buffer-swap pulse.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clk_en           : global enable; low freezes everything and forces strobes 0
//   start            : begin a run (sampled in IDLE only)
//   cfg_depth        : writes per buffer      (latched on start)
//   cfg_iter_cnt     : reads per buffer       (latched on start)
//   cfg_num_frames   : buffers to fill in run (latched on start)
//   wr_req / rd_req  : producer / consumer requests
//   wen_in / ren_in  : core strobes, also the zero-latency accepts
//   switch_db        : buffer swap pulse, one cycle per SWITCH visit
//   busy             : run in progress
//   done             : one-cycle pulse after the final read
//   cfg_err          : one-cycle pulse after a start with a zero config value
//   wr_cnt / rd_cnt  : current per-buffer counts
// -----------------------------------------------------------------------------
module db_phase_ctrl
  import db_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_depth,
  input  logic [CNT_W-1:0] cfg_iter_cnt,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic             wen_in,
  output logic             ren_in,
  output logic             switch_db,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  state_e           state_q;
  logic [CNT_W-1:0] depth_q;
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] wframes_q;
  logic [CNT_W-1:0] wframes_d;
  logic             done_q;
  logic             cfg_err_q;

  logic cfg_ok;
  logic run_start;
  logic cnt_clr;
  logic wr_avail, wr_last;
  logic rd_avail, rd_last;
  logic wr_fin, rd_fin;

  assign cfg_ok    = (cfg_depth != '0) & (cfg_iter_cnt != '0) & (cfg_num_frames != '0);
  assign run_start = (state_q == ST_IDLE) & start & cfg_ok;
  assign wframes_d = wframes_q + CNT_W'(1);

  // Strobes are combinational so a request is accepted in the same cycle.
  assign wen_in    = clk_en & wr_req & wr_avail &
                     ((state_q == ST_FILL) | (state_q == ST_STEADY));
  assign ren_in    = clk_en & rd_req & rd_avail &
                     ((state_q == ST_STEADY) | (state_q == ST_DRAIN));
  assign switch_db = clk_en & (state_q == ST_SWITCH);

  // Both budgets restart at the beginning of a run and at every buffer swap.
  assign cnt_clr = run_start | (state_q == ST_SWITCH);

  db_budget_cnt #(.W(CNT_W)) u_wr_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (clk_en),
    .clr_i   (cnt_clr),
    .inc_i   (wen_in),
    .limit_i (depth_q),
    .cnt_o   (wr_cnt),
    .avail_o (wr_avail),
    .last_o  (wr_last)
  );

  db_budget_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (clk_en),
    .clr_i   (cnt_clr),
    .inc_i   (ren_in),
    .limit_i (iter_q),
    .cnt_o   (rd_cnt),
    .avail_o (rd_avail),
    .last_o  (rd_last)
  );

  // A side is finished once its post-update count reaches the budget. This
  // covers a final write and a final read that land in the same cycle.
  assign wr_fin = (wr_cnt == depth_q) | wr_last;
  assign rd_fin = (rd_cnt == iter_q)  | rd_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      depth_q   <= '0;
      iter_q    <= '0;
      frames_q  <= '0;
      wframes_q <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (clk_en) begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              depth_q   <= cfg_depth;
              iter_q    <= cfg_iter_cnt;
              frames_q  <= cfg_num_frames;
              wframes_q <= '0;
              state_q   <= ST_FILL;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (wr_last) state_q <= ST_SWITCH;
        end
        ST_SWITCH: begin
          wframes_q <= wframes_d;
          state_q   <= (wframes_d == frames_q) ? ST_DRAIN : ST_STEADY;
        end
        ST_STEADY: begin
          if (wr_fin & rd_fin) state_q <= ST_SWITCH;
        end
        ST_DRAIN: begin
          if (rd_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule : db_phase_ctrl

// File: tb/tb_db_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_db_phase_ctrl
// Self-checking bench for db_phase_ctrl. The reference model tracks running
// totals: total writes, total reads, swaps completed, and whether a swap is due.
// It derives the legal strobes and the per-buffer counts from those totals.
// -----------------------------------------------------------------------------
module tb_db_phase_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_en;
  logic         start;
  logic [W-1:0] cfg_depth;
  logic [W-1:0] cfg_iter_cnt;
  logic [W-1:0] cfg_num_frames;
  logic         wr_req;
  logic         rd_req;
  logic         wen_in;
  logic         ren_in;
  logic         switch_db;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic [W-1:0] wr_cnt;
  logic [W-1:0] rd_cnt;

  db_phase_ctrl #(.CNT_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .start          (start),
    .cfg_depth      (cfg_depth),
    .cfg_iter_cnt   (cfg_iter_cnt),
    .cfg_num_frames (cfg_num_frames),
    .wr_req         (wr_req),
    .rd_req         (rd_req),
    .wen_in         (wen_in),
    .ren_in         (ren_in),
    .switch_db      (switch_db),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .wr_cnt         (wr_cnt),
    .rd_cnt         (rd_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: totals for the whole run.
  int m_d, m_i, m_n;
  int m_wt, m_rt, m_sw;
  bit m_busy, m_in_sw, m_done, m_err;

  // Observed statistics for the current scenario.
  int s_busy, s_sw, s_ren, s_both, s_stall, s_err;
  int cur_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    s_busy = 0; s_sw = 0; s_ren = 0; s_both = 0; s_stall = 0; s_err = 0;
  endtask

  // One clock cycle: compare at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit e_wen, e_ren, e_sw, nd, ne;
    int e_wc, e_rc;
    @(negedge clk);
    e_sw  = clk_en && m_busy && m_in_sw;
    e_wen = clk_en && m_busy && !m_in_sw && wr_req &&
            (m_sw < m_n) && (m_wt < (m_sw + 1) * m_d);
    e_ren = clk_en && m_busy && !m_in_sw && rd_req &&
            (m_sw >= 1) && (m_rt < m_sw * m_i);
    e_wc  = m_wt - m_sw * m_d;
    e_rc  = (m_sw == 0) ? 0 : m_rt - (m_sw - 1) * m_i;
    check("wen_in",    32'(wen_in),    32'(e_wen));
    check("ren_in",    32'(ren_in),    32'(e_ren));
    check("switch_db", 32'(switch_db), 32'(e_sw));
    check("busy",      32'(busy),      32'(m_busy));
    check("done",      32'(done),      32'(m_done));
    check("cfg_err",   32'(cfg_err),   32'(m_err));
    check("wr_cnt",    32'(wr_cnt),    32'(e_wc));
    check("rd_cnt",    32'(rd_cnt),    32'(e_rc));
    s_busy  += int'(busy);
    s_sw    += int'(switch_db);
    s_ren   += int'(ren_in);
    s_both  += int'(wen_in & ren_in);
    s_stall += int'(ren_in && (int'(wr_cnt) == cur_d));
    s_err   += int'(cfg_err);
    @(posedge clk);
    if (reset) begin
      m_wt = 0; m_rt = 0; m_sw = 0;
      m_busy = 0; m_in_sw = 0; m_done = 0; m_err = 0;
    end else if (clk_en) begin
      nd = 0; ne = 0;
      if (!m_busy) begin
        if (start) begin
          if (cfg_depth != 0 && cfg_iter_cnt != 0 && cfg_num_frames != 0) begin
            m_d = int'(cfg_depth); m_i = int'(cfg_iter_cnt); m_n = int'(cfg_num_frames);
            m_wt = 0; m_rt = 0; m_sw = 0; m_busy = 1; m_in_sw = 0;
          end else begin
            ne = 1;
          end
        end
      end else if (m_in_sw) begin
        m_sw++;
        m_in_sw = 0;
      end else begin
        m_wt += int'(e_wen);
        m_rt += int'(e_ren);
        if (m_sw < m_n && m_wt == (m_sw + 1) * m_d && m_rt == m_sw * m_i)
          m_in_sw = 1;
        else if (m_sw == m_n && m_rt == m_n * m_i) begin
          m_busy = 0;
          nd = 1;
        end
      end
      m_done = nd;
      m_err  = ne;
    end
    #1;
  endtask

  task automatic run(input int d, input int i, input int n,
                     input bit drop_sw, input bit drop_st, input bit rst_at2, input bit rnd);
    int budget;
    bit did_sw, did_st, stop;
    cfg_depth = W'(d); cfg_iter_cnt = W'(i); cfg_num_frames = W'(n);
    cur_d = d;
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0; did_sw = 0; did_st = 0; stop = 0;
    while (!stop && (m_busy || m_done)) begin
      if (rnd) begin
        wr_req = ($urandom_range(0, 3) != 0);
        rd_req = ($urandom_range(0, 3) != 0);
        clk_en = ($urandom_range(0, 9) != 0);
        start  = ($urandom_range(0, 7) == 0);
      end
      if (drop_sw && !did_sw && m_in_sw) begin
        clk_en = 1'b0;
        repeat (5) step();
        clk_en = 1'b1;
        did_sw = 1;
      end else if (drop_st && !did_st && m_busy && !m_in_sw && m_sw >= 1 &&
                   m_sw < m_n && m_wt > m_sw * m_d) begin
        clk_en = 1'b0;
        repeat (5) step();
        clk_en = 1'b1;
        did_st = 1;
      end else if (rst_at2 && m_busy && m_sw == 0 && m_wt == 2) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        stop = 1;
      end else begin
        step();
      end
      budget++;
      if (budget > 3000) begin
        check("cycle_budget", 32'(budget), 32'(0));
        stop = 1;
      end
    end
    clk_en = 1'b1; wr_req = 1'b1; rd_req = 1'b1; start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    cfg_depth = '0; cfg_iter_cnt = '0; cfg_num_frames = '0;
    m_d = 0; m_i = 0; m_n = 0; m_wt = 0; m_rt = 0; m_sw = 0;
    m_busy = 0; m_in_sw = 0; m_done = 0; m_err = 0; cur_d = 0;
    clear_stats();
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    // Single frame, requests held high.
    run(4, 4, 1, 0, 0, 0, 0);
    check("t1_busy_cycles", 32'(s_busy), 32'(9));
    check("t1_switches",    32'(s_sw),   32'(1));
    check("t1_reads",       32'(s_ren),  32'(4));

    // Three frames, writes stall while reads continue.
    run(9, 27, 3, 0, 0, 0, 0);
    check("t2_switches",    32'(s_sw),    32'(3));
    check("t2_reads",       32'(s_ren),   32'(81));
    check("t2_stall_reads", 32'(s_stall), 32'(36));

    // Final write and final read land in the same STEADY cycle.
    run(3, 3, 2, 0, 0, 0, 0);
    check("t3_busy_cycles", 32'(s_busy), 32'(11));
    check("t3_overlap",     32'(s_both), 32'(3));

    // clk_en dropped for 5 cycles in SWITCH and again in STEADY.
    run(3, 3, 2, 1, 1, 0, 0);
    check("t4_busy_cycles", 32'(s_busy), 32'(21));
    check("t4_switches",    32'(s_sw),   32'(2));
    check("t4_reads",       32'(s_ren),  32'(6));

    // Zero depth is rejected.
    cfg_depth = '0; cfg_iter_cnt = W'(4); cfg_num_frames = W'(1);
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("t5_cfg_err_pulses", 32'(s_err),  32'(1));
    check("t5_busy_cycles",    32'(s_busy), 32'(0));

    // Reset in the middle of FILL, then a fresh run.
    run(5, 2, 2, 0, 0, 1, 0);
    check("t6_busy_after_rst",   32'(busy),   32'(0));
    check("t6_wr_cnt_after_rst", 32'(wr_cnt), 32'(0));
    run(2, 3, 2, 0, 0, 0, 0);
    check("t6_switches", 32'(s_sw),  32'(2));
    check("t6_reads",    32'(s_ren), 32'(6));

    // Random budgets, requests, enables and stray starts.
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)),
          int'($urandom_range(1, 4)), 0, 0, 0, 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_db_phase_ctrl

// File: doc/db_phase_ctrl.md
# db_phase_ctrl

Phase sequencer for the double-buffered memory core in DB mode (mode 3). It arbitrates producer write requests and consumer read requests onto the core's `wen_in` and `ren_in`. It counts writes against `depth` and reads against `iter_cnt` for each buffer, and issues the one-cycle `switch_db` pulse that swaps the buffers. It sits between the tile's streaming interfaces and the memory core, and enforces by construction the write/read budget per buffer that formal benches otherwise have to assume.

## Interface
Parameters:
- CNT_W, 16, width of depth, iteration and frame counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  global enable; low freezes all state and counters.
- start  in  1  begin a run; sampled in IDLE only.
- cfg_depth  in  CNT_W  writes per buffer; latched on start.
- cfg_iter_cnt  in  CNT_W  reads per buffer; latched on start.
- cfg_num_frames  in  CNT_W  buffers to fill in this run; latched on start.
- wr_req  in  1  producer has a word to write.
- rd_req  in  1  consumer requests a read.
- wen_in  out  1  write strobe to the core; also the producer's accept.
- ren_in  out  1  read strobe to the core; also the consumer's accept.
- switch_db  out  1  buffer swap pulse to the core.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle run-complete pulse.
- cfg_err  out  1  one-cycle pulse when start carries a zero config value.
- wr_cnt, rd_cnt  out  CNT_W  current per-buffer counts, for debug and verification.

## Operation
States: IDLE, FILL, SWITCH, STEADY, DRAIN.
- IDLE: all strobes are 0.
  - start=1 with depth, iter_cnt and num_frames all nonzero: latch config, clear counters, go to FILL.
  - start=1 with any of them zero: pulse cfg_err and stay in IDLE.
- FILL: `wen_in = wr_req & (wr_cnt < depth)`; `ren_in = 0`.
  - The write that brings wr_cnt to depth moves the FSM to SWITCH.
- SWITCH: `switch_db = 1`, no strobes, both counters cleared, wframes incremented.
  - Next state is DRAIN if wframes (after increment) equals num_frames, otherwise STEADY.
- STEADY: writes are gated as in FILL; `ren_in = rd_req & (rd_cnt < iter_cnt)`.
  - Both strobes may fire in the same cycle.
  - Once a side has exhausted its budget, its strobe stays low until the other side finishes.
  - When wr_cnt equals depth and rd_cnt equals iter_cnt, go to SWITCH. This includes the case where the final write and the final read land in the same cycle; the transition is taken from the post-update counts.
- DRAIN: reads only. The read that brings rd_cnt to iter_cnt moves the FSM to IDLE and sets done for the next cycle.
- Counters use plain CNT_W unsigned arithmetic. They never exceed their limit because the strobes are gated, so they cannot wrap.
- start is ignored while busy.

## Timing
- wen_in and ren_in are combinational from the request input, the state and the counters (zero-latency accept). Counters update on the same edge the strobe is sampled.
- switch_db is a Moore output: exactly one cycle per SWITCH visit.
- done and cfg_err are registered: high for exactly one cycle, the cycle after the triggering event.
- clk_en=0:
  - wen_in, ren_in and switch_db are forced to 0.
  - State, counters, and any pending done/cfg_err are held.
  - A SWITCH state is held and reissues its pulse when clk_en returns.
- Reset values: state IDLE; counters and frame counters 0; all outputs 0.
- Reset asserted mid-run: next cycle is IDLE with all outputs 0; any partially filled buffer is abandoned.
- Minimum run for num_frames=N: depth·N + iter_cnt + N cycles, assuming requests are always high and STEADY reads fully overlap writes.

## Structure
- Package db_ctrl_pkg: state enum (IDLE, FILL, SWITCH, STEADY, DRAIN) and the CNT_W default constant.
- Sub-module db_budget_cnt: a clear/increment counter with a limit compare. It provides `avail = cnt < limit` and `last = (cnt == limit-1) & inc`. It is instantiated twice, once for writes and once for reads.
- Everything else, the FSM and the frame counter, stays in the top module.

## Test plan
- Single frame, depth=4, iter=4, frames=1, requests held high:
  - Cycles 0–3: wen_in.
  - Cycle 4: switch_db.
  - Cycles 5–8: ren_in only.
  - Cycle 9: done.
- Frames=3, depth=9, iter=27:
  - Writes stall at wr_cnt=9 while reads continue.
  - switch_db pulses exactly 3 times.
  - Total ren_in count is 81.
- Simultaneous finish, depth=iter=3: the final write and the final read land in the same STEADY cycle; SWITCH is entered on the next cycle with no extra strobe.
- clk_en dropped for 5 cycles during SWITCH and during STEADY: no strobes, counters frozen, switch_db pulse reissued after re-enable, final counts unchanged.
- start with depth=0: cfg_err pulses for 1 cycle, busy stays 0. Reset asserted at wr_cnt=2: IDLE next cycle, wr_cnt=0, and a fresh start works normally.
